// File: rtl/flag_seq_monitor.sv
// flag_seq_monitor: synchronises two async flags, counts their rising edges and checks f1->f2 ordering within a window
module flag_seq_monitor #(
  parameter int CW = 8,
  parameter int WINDOW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f1,
  input  logic          f2,
  input  logic          en,
  input  logic          clr,
  output logic          f1_rise,
  output logic          f2_rise,
  output logic [CW-1:0] f1_cnt,
  output logic [CW-1:0] f2_cnt,
  output logic [CW-1:0] match_cnt,
  output logic          match,
  output logic          timeout,
  output logic          armed
);
  typedef enum logic {IDLE, ARMED} state_t;
  localparam logic [7:0] WLAST = 8'(WINDOW - 1);
  state_t state, state_n;
  logic [7:0] win_cnt, win_n;
  logic match_n, timeout_n;
  logic [2:0] sy1, sy2;
  logic q1, q2;
  assign q1 = en & sy1[1] & ~sy1[2];
  assign q2 = en & sy2[1] & ~sy2[2];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      win_cnt <= '0;
    end else begin
      state <= state_n;
      win_cnt <= win_n;
    end
  end
  always_comb begin
    state_n = state;
    win_n = win_cnt;
    match_n = 1'b0;
    timeout_n = 1'b0;
    if (clr) begin
      state_n = IDLE;
      win_n = '0;
    end else if (en) begin
      if (state == IDLE) begin
        if (q1) begin
          state_n = ARMED;
          win_n = '0;
        end
      end else if (q2) begin
        state_n = IDLE;
        win_n = '0;
        match_n = 1'b1;
      end else if (q1) begin
        win_n = '0;
      end else if (win_cnt == WLAST) begin
        state_n = IDLE;
        win_n = '0;
        timeout_n = 1'b1;
      end else begin
        win_n = win_cnt + 8'd1;
      end
    end
  end
  always_comb armed = (state == ARMED);
  always_ff @(posedge clk) begin
    if (rst) begin
      sy1 <= '0;
      sy2 <= '0;
      f1_rise <= 1'b0;
      f2_rise <= 1'b0;
      match <= 1'b0;
      timeout <= 1'b0;
      f1_cnt <= '0;
      f2_cnt <= '0;
      match_cnt <= '0;
    end else begin
      sy1 <= {sy1[1:0], f1};
      sy2 <= {sy2[1:0], f2};
      f1_rise <= q1 & ~clr;
      f2_rise <= q2 & ~clr;
      match <= match_n;
      timeout <= timeout_n;
      f1_cnt <= clr ? '0 : f1_cnt + CW'(q1 & ~&f1_cnt);
      f2_cnt <= clr ? '0 : f2_cnt + CW'(q2 & ~&f2_cnt);
      match_cnt <= clr ? '0 : match_cnt + CW'(match_n & ~&match_cnt);
    end
  end
endmodule

// File: tb/tb_flag_seq_monitor.sv
// tb_flag_seq_monitor: randomized and directed checks of flag_seq_monitor against a behavioural model
module tb_flag_seq_monitor;
  localparam int CW = 8;
  localparam int WINDOW = 16;
  localparam int MAXC = 255;
  logic clk = 1'b0;
  logic rst = 1'b1, f1 = 1'b0, f2 = 1'b0, en = 1'b0, clr = 1'b0;
  logic f1_rise, f2_rise, match, timeout, armed;
  logic [CW-1:0] f1_cnt, f2_cnt, match_cnt;
  logic [28:0] obs, exp_v;
  logic [3:0] h1 = '0, h2 = '0;
  int m1c = 0, m2c = 0, mmc = 0, age = 0;
  bit marm = 0, mp1 = 0, mp2 = 0, mm = 0, mt = 0;
  int n_cmp = 0, n_fail = 0, cyc = 0;
  flag_seq_monitor #(.CW(CW), .WINDOW(WINDOW)) dut (
    .clk(clk), .rst(rst), .f1(f1), .f2(f2), .en(en), .clr(clr),
    .f1_rise(f1_rise), .f2_rise(f2_rise), .f1_cnt(f1_cnt), .f2_cnt(f2_cnt),
    .match_cnt(match_cnt), .match(match), .timeout(timeout), .armed(armed)
  );
  always #5 clk = ~clk;
  assign obs = {f1_rise, f2_rise, match, timeout, armed, f1_cnt, f2_cnt, match_cnt};
  task automatic tick(input logic fa, input logic fb, input logic ea, input logic ca, input logic ra);
    bit e1, e2;
    f1 = fa; f2 = fb; en = ea; clr = ca; rst = ra;
    @(posedge clk);
    cyc++;
    if (ra) begin
      h1 = '0; h2 = '0; m1c = 0; m2c = 0; mmc = 0; age = 0;
      marm = 0; mp1 = 0; mp2 = 0; mm = 0; mt = 0;
    end else begin
      h1 = {h1[2:0], fa};
      h2 = {h2[2:0], fb};
      e1 = h1[2] && !h1[3] && ea && !ca;
      e2 = h2[2] && !h2[3] && ea && !ca;
      mp1 = e1; mp2 = e2; mm = 0; mt = 0;
      if (ca) begin
        m1c = 0; m2c = 0; mmc = 0; marm = 0; age = 0;
      end else begin
        if (e1) m1c = (m1c < MAXC) ? m1c + 1 : MAXC;
        if (e2) m2c = (m2c < MAXC) ? m2c + 1 : MAXC;
        if (marm && e2) begin
          mm = 1; marm = 0;
          mmc = (mmc < MAXC) ? mmc + 1 : MAXC;
        end else if (marm && e1) begin
          age = 0;
        end else if (marm && ea) begin
          age++;
          if (age == WINDOW) begin mt = 1; marm = 0; end
        end else if (!marm && e1) begin
          marm = 1; age = 0;
        end
      end
    end
    exp_v = {mp1, mp2, mm, mt, marm, 8'(m1c), 8'(m2c), 8'(mmc)};
    #1;
  endtask
  task automatic prep();
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (obs !== 29'h0) begin n_fail++; $display("FAIL reset cyc=%0d got=%h exp=0", cyc, obs); end
    end
  endtask
  task automatic test_first_rise();
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (f1_rise !== (i == 3)) begin n_fail++; $display("FAIL first_rise_latency i=%0d got=%b exp=%b", i, f1_rise, i == 3); end
      n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL first_rise_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
    end
    n_cmp++;
    if ({f1_cnt, armed} !== {8'd1, 1'b1}) begin n_fail++; $display("FAIL first_rise_cnt got=%0d/%b exp=1/1", f1_cnt, armed); end
  endtask
  task automatic test_match();
    int nm = 0, nt = 0;
    prep();
    for (int i = 0; i < 15; i++) begin
      tick(1'b1, i >= 5, 1'b1, 1'b0, 1'b0);
      nm += int'(match); nt += int'(timeout);
      n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL match_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
    end
    n_cmp++;
    if (nm != 1 || nt != 0 || match_cnt !== 8'd1 || armed !== 1'b0) begin
      n_fail++; $display("FAIL match_result got m=%0d t=%0d cnt=%0d arm=%b exp m=1 t=0 cnt=1 arm=0", nm, nt, match_cnt, armed);
    end
  endtask
  task automatic test_timeout();
    int nt = 0, rise_at = -1, to_at = -1;
    prep();
    for (int i = 0; i < WINDOW + 8; i++) begin
      tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      if (f1_rise) rise_at = i;
      if (timeout) begin nt++; to_at = i; end
      n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL timeout_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
    end
    n_cmp++;
    if (nt != 1 || to_at - rise_at != WINDOW || match_cnt !== 8'd0) begin
      n_fail++; $display("FAIL timeout_result got n=%0d dist=%0d mcnt=%0d exp n=1 dist=%0d mcnt=0", nt, to_at - rise_at, match_cnt, WINDOW);
    end
  endtask
  task automatic test_boundary();
    int nm, nt;
    for (int late = 0; late < 2; late++) begin
      nm = 0; nt = 0;
      prep();
      for (int i = 0; i < WINDOW + 8; i++) begin
        tick(1'b1, i >= WINDOW + late, 1'b1, 1'b0, 1'b0);
        nm += int'(match); nt += int'(timeout);
        n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL boundary_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
      end
      n_cmp++;
      if (nm != 1 - late || nt != late) begin
        n_fail++; $display("FAIL boundary late=%0d got m=%0d t=%0d exp m=%0d t=%0d", late, nm, nt, 1 - late, late);
      end
    end
  endtask
  task automatic test_simultaneous();
    int nm = 0;
    prep();
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, i < 3 || i >= 7, 1'b1, 1'b0, 1'b0);
      nm += int'(match);
      if (i == 2) begin
        n_cmp++;
        if (armed !== 1'b1 || match !== 1'b0) begin n_fail++; $display("FAIL simultaneous_arm got arm=%b m=%b exp arm=1 m=0", armed, match); end
      end
      n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL simultaneous_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
    end
    n_cmp++;
    if (nm != 1) begin n_fail++; $display("FAIL simultaneous_match got=%0d exp=1", nm); end
  endtask
  task automatic test_saturate();
    prep();
    for (int i = 0; i < 603; i++) begin
      tick(i < 600 && i % 2 == 0, 1'b0, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL saturate_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
    end
    n_cmp++;
    if (f1_cnt !== 8'd255) begin n_fail++; $display("FAIL saturate_cnt got=%0d exp=255", f1_cnt); end
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (obs !== 29'h0) begin n_fail++; $display("FAIL saturate_clr got=%h exp=0", obs); end
  endtask
  task automatic test_en_freeze();
    int snap1, snap2, snapm;
    bit snap_arm;
    logic a = 1'b0, b = 1'b0;
    prep();
    for (int i = 0; i < 4; i++) tick(i < 2, 1'b0, 1'b1, 1'b0, 1'b0);
    snap1 = m1c; snap2 = m2c; snapm = mmc; snap_arm = marm;
    for (int i = 0; i < 40; i++) begin
      a = a ^ ($urandom_range(0, 1) == 0);
      b = b ^ ($urandom_range(0, 1) == 0);
      tick(a, b, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({f1_rise, f2_rise, match, timeout} !== 4'b0 || f1_cnt !== 8'(snap1) || f2_cnt !== 8'(snap2) ||
          match_cnt !== 8'(snapm) || armed !== snap_arm) begin
        n_fail++; $display("FAIL en_freeze cyc=%0d got=%h", cyc, obs);
      end
    end
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL en_resume_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
    end
  endtask
  task automatic test_rst_mid();
    prep();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (armed !== 1'b1) begin n_fail++; $display("FAIL rst_mid_arm got=%b exp=1", armed); end
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (obs !== 29'h0) begin n_fail++; $display("FAIL rst_mid got=%h exp=0", obs); end
  endtask
  task automatic test_random();
    logic a = 1'b0, b = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      a = a ^ ($urandom_range(0, 2) == 0);
      b = b ^ ($urandom_range(0, 3) == 0);
      tick(a, b, $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0);
      n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
    end
  endtask
  initial begin
    test_reset();
    test_first_rise();
    test_match();
    test_timeout();
    test_boundary();
    test_simultaneous();
    test_saturate();
    test_en_freeze();
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
